main_memory_ctrl: RTL and testbench

Main-memory responder on the cache-to-memory block interface of the Project 3 memory hierarchy. It holds 1 KiB as 64 blocks of 128 bits and serves whole-block reads and whole-block writes. Each access has a fixed, parameterised latency and uses a request/ready handshake. It also keeps saturating read and write access counters that the bench uses to check miss and write-through traffic.

---
 rtl/main_memory_ctrl.sv | 113 +++++++++++
 tb/tb_main_memory_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/main_memory_ctrl.sv
// main_memory_ctrl
// Block-granular main-memory responder: 64 blocks of 128 bits, whole-block
// reads and writes with a fixed LATENCY, a request/ready handshake and
// saturating completed-read / completed-write counters.
module main_memory_ctrl #(
  parameter int LATENCY = 4,   // accept-to-commit edges, 1..15
  parameter int ADDR_W  = 10   // byte address width
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_address,
  input  logic [127:0]      mem_write_data,
  output logic [127:0]      mem_read_data,
  output logic              mem_ready,
  output logic              busy,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
);

  // Block index comes from the bits above the 16-byte block offset.
  localparam int IDX_W = ADDR_W - 4;
  localparam int NBLK  = 1 << IDX_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  logic [3:0]       lat_cnt_reg;
  logic             wr_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [127:0]     data_reg;

  logic [127:0]     blk [NBLK];

  // The byte offset inside a block never selects anything.
  logic unused_addr_bits;
  assign unused_addr_bits = ^mem_address[3:0];

  // A write lands in the array on the same edge the FSM leaves BUSY.
  logic commit_write;
  assign commit_write = (state_reg == BUSY) && (lat_cnt_reg == 4'd0) && wr_reg;

  // Control FSM with registered handshake outputs, read data and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      lat_cnt_reg   <= 4'd0;
      wr_reg        <= 1'b0;
      idx_reg       <= '0;
      data_reg      <= '0;
      mem_read_data <= '0;
      mem_ready     <= 1'b0;
      busy          <= 1'b0;
      rd_count      <= 16'd0;
      wr_count      <= 16'd0;
    end else begin
      mem_ready <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (mem_req) begin
            // Latch everything now; later input changes are irrelevant.
            wr_reg      <= mem_write;
            idx_reg     <= mem_address[ADDR_W-1:4];
            data_reg    <= mem_write_data;
            lat_cnt_reg <= 4'(LATENCY - 1);
            state_reg   <= BUSY;
            busy        <= 1'b1;
          end
        end
        BUSY: begin
          if (lat_cnt_reg != 4'd0) begin
            lat_cnt_reg <= lat_cnt_reg - 4'd1;
          end else begin
            state_reg <= DONE;
            mem_ready <= 1'b1;
            if (wr_reg) begin
              if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
            end else begin
              mem_read_data <= blk[idx_reg];
              if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
            end
          end
        end
        DONE: begin
          // One dead cycle after completion: requests here are dropped.
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // Block storage; reset clears it so reads after reset return zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < NBLK; b++) begin
        blk[b] <= '0;
      end
    end else if (commit_write) begin
      blk[idx_reg] <= data_reg;
    end
  end

endmodule

// File: tb/tb_main_memory_ctrl.sv
// tb_main_memory_ctrl
// Three responders (LATENCY 4, 1, 15) driven by randomized and directed
// transactions, checked every cycle against a transaction-level model.
module tb_main_memory_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         req    [3];
  logic         wr     [3];
  logic [9:0]   addr   [3];
  logic [127:0] wdata  [3];
  logic [127:0] rdata  [3];
  logic         ready  [3];
  logic         busy_o [3];
  logic [15:0]  rdc    [3];
  logic [15:0]  wrc    [3];

  int n_checks = 0;
  int n_errors = 0;

  function automatic int lat_of(input int i);
    return (i == 0) ? 4 : (i == 1) ? 1 : 15;
  endfunction

  main_memory_ctrl #(.LATENCY(4), .ADDR_W(10)) u_dut4 (
    .clk(clk), .rst(rst), .mem_req(req[0]), .mem_write(wr[0]),
    .mem_address(addr[0]), .mem_write_data(wdata[0]),
    .mem_read_data(rdata[0]), .mem_ready(ready[0]), .busy(busy_o[0]),
    .rd_count(rdc[0]), .wr_count(wrc[0]));

  main_memory_ctrl #(.LATENCY(1), .ADDR_W(10)) u_dut1 (
    .clk(clk), .rst(rst), .mem_req(req[1]), .mem_write(wr[1]),
    .mem_address(addr[1]), .mem_write_data(wdata[1]),
    .mem_read_data(rdata[1]), .mem_ready(ready[1]), .busy(busy_o[1]),
    .rd_count(rdc[1]), .wr_count(wrc[1]));

  main_memory_ctrl #(.LATENCY(15), .ADDR_W(10)) u_dut15 (
    .clk(clk), .rst(rst), .mem_req(req[2]), .mem_write(wr[2]),
    .mem_address(addr[2]), .mem_write_data(wdata[2]),
    .mem_read_data(rdata[2]), .mem_ready(ready[2]), .busy(busy_o[2]),
    .rd_count(rdc[2]), .wr_count(wrc[2]));

  // ---------------- behavioural model ----------------
  // Per instance: a memory image, counters, and the edge numbers of the
  // accepted access (acceptance, commit) plus the earliest next accept.
  logic [127:0] m_mem   [3][64];
  logic [127:0] m_rdata [3];
  int           m_rdc   [3];
  int           m_wrc   [3];
  int           p_acc   [3];
  int           p_commit[3];
  int           free_at [3];
  logic         p_wr    [3];
  int           p_idx   [3];
  logic [127:0] p_data  [3];
  int           cyc = 0;

  initial begin
    for (int i = 0; i < 3; i++) begin
      p_acc[i] = -10; p_commit[i] = -10; free_at[i] = 0;
      m_rdc[i] = 0; m_wrc[i] = 0; m_rdata[i] = '0;
      req[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
    end
  end

  task automatic cmp(input string name, input int i, input logic [127:0] got,
                     input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s inst%0d cyc=%0d got=%h exp=%h", name, i, cyc, got, exp);
    end
  endtask

  // Single compare process: advance the model by one edge, then check.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        for (int b = 0; b < 64; b++) m_mem[i][b] = '0;
        m_rdata[i] = '0; m_rdc[i] = 0; m_wrc[i] = 0;
        p_acc[i] = -10; p_commit[i] = -10; free_at[i] = 0;
      end else begin
        if (cyc == p_commit[i]) begin
          if (p_wr[i]) begin
            m_mem[i][p_idx[i]] = p_data[i];
            m_wrc[i] = (m_wrc[i] < 65535) ? m_wrc[i] + 1 : 65535;
          end else begin
            m_rdata[i] = m_mem[i][p_idx[i]];
            m_rdc[i] = (m_rdc[i] < 65535) ? m_rdc[i] + 1 : 65535;
          end
        end
        if (req[i] && cyc >= free_at[i]) begin
          p_acc[i]    = cyc;
          p_commit[i] = cyc + lat_of(i);
          free_at[i]  = cyc + lat_of(i) + 2;
          p_wr[i]     = wr[i];
          p_idx[i]    = int'(addr[i][9:4]);
          p_data[i]   = wdata[i];
        end
      end
      cmp("ready", i, 128'(ready[i]), 128'(cyc == p_commit[i]));
      cmp("busy", i, 128'(busy_o[i]), 128'(cyc >= p_acc[i] && cyc <= p_commit[i]));
      cmp("rd_count", i, 128'(rdc[i]), 128'(m_rdc[i]));
      cmp("wr_count", i, 128'(wrc[i]), 128'(m_wrc[i]));
      cmp("read_data", i, rdata[i], m_rdata[i]);
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic lit(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // One handshake: hold the request until ready, scrambling every input
  // (including mem_req) while the access is in flight.
  task automatic txn(input int i, input bit w, input logic [9:0] a, input logic [127:0] d,
                     output logic [127:0] rd, output int lat_seen, output int busy_seen);
    bit got;
    rd = '0; lat_seen = 0; busy_seen = 0; got = 1'b0;
    @(negedge clk);
    @(negedge clk);
    req[i] = 1'b1; wr[i] = w; addr[i] = a; wdata[i] = d;
    for (int n = 1; n <= lat_of(i) + 4 && !got; n++) begin
      @(negedge clk);
      if (busy_o[i]) busy_seen++;
      if (ready[i]) begin
        got = 1'b1; lat_seen = n; rd = rdata[i];
      end else begin
        req[i] = 1'($urandom); wr[i] = 1'($urandom); addr[i] = 10'($urandom);
        wdata[i] = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    req[i] = 1'b0;
    @(negedge clk);
    if (busy_o[i]) busy_seen++;
    if (!got) begin
      n_checks++; n_errors++;
      $display("FAIL timeout inst%0d addr=%h got=no_ready exp=ready", i, a);
    end
    $display("txn inst%0d %s addr=%h data=%h lat=%0d", i, w ? "WR" : "RD", a,
             w ? d : rd, lat_seen);
  endtask

  logic [127:0] rd, val;
  int lat_seen, busy_seen;
  bit seen_ready;

  initial begin
    repeat (3) @(negedge clk);
    lit("reset_rd_count", 128'(rdc[0]), 128'd0);
    lit("reset_ready", 128'(ready[0]), 128'd0);
    rst = 1'b0;

    // Reset then read: zero data, one read counted.
    txn(0, 1'b0, 10'h3F0, '0, rd, lat_seen, busy_seen);
    lit("first_read_data", rd, 128'd0);
    lit("first_read_lat", 128'(lat_seen), 128'd5);
    lit("first_rd_count", 128'(rdc[0]), 128'd1);
    lit("first_wr_count", 128'(wrc[0]), 128'd0);
    lit("busy_span4", 128'(busy_seen), 128'd5);

    // Write then aliased read-back.
    val = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    txn(0, 1'b1, 10'h0A4, val, rd, lat_seen, busy_seen);
    lit("write_wr_count", 128'(wrc[0]), 128'd1);
    txn(0, 1'b0, 10'h0A0, '0, rd, lat_seen, busy_seen);
    lit("alias_read", rd, val);
    lit("alias_word0", 128'(rd[127:96]), 128'h01234567);
    lit("after_busy_req_rd_count", 128'(rdc[0]), 128'd2);

    // Latency extremes.
    txn(1, 1'b1, 10'h010, 128'hA5A5, rd, lat_seen, busy_seen);
    lit("lat1_ready_edge", 128'(lat_seen), 128'd2);
    lit("lat1_busy_span", 128'(busy_seen), 128'd2);
    txn(2, 1'b1, 10'h020, 128'h5A5A, rd, lat_seen, busy_seen);
    lit("lat15_ready_edge", 128'(lat_seen), 128'd16);
    lit("lat15_busy_span", 128'(busy_seen), 128'd16);
    txn(2, 1'b0, 10'h02C, '0, rd, lat_seen, busy_seen);
    lit("lat15_read", rd, 128'h5A5A);

    // Randomized traffic on a few blocks so reads hit earlier writes.
    for (int i = 0; i < 3; i++) begin
      for (int t = 0; t < ((i == 2) ? 6 : 30); t++) begin
        txn(i, 1'($urandom), 10'($urandom_range(0, 7) * 16 + $urandom_range(0, 15)),
            {$urandom, $urandom, $urandom, $urandom}, rd, lat_seen, busy_seen);
      end
    end

    // Mid-access reset aborts a write.
    seen_ready = 1'b0;
    @(negedge clk);
    req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 10'h100; wdata[0] = '1;
    @(negedge clk);
    req[0] = 1'b0;
    if (ready[0]) seen_ready = 1'b1;
    @(negedge clk);
    if (ready[0]) seen_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    if (ready[0]) seen_ready = 1'b1;
    rst = 1'b0;
    lit("midreset_no_ready", 128'(seen_ready), 128'd0);
    lit("midreset_wr_count", 128'(wrc[0]), 128'd0);
    txn(0, 1'b0, 10'h100, '0, rd, lat_seen, busy_seen);
    lit("midreset_read", rd, 128'd0);

    // Saturation of the read counter.
    val = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
    txn(0, 1'b1, 10'h230, val, rd, lat_seen, busy_seen);
    @(negedge clk);
    force u_dut4.rd_count = 16'hFFFE;
    m_rdc[0] = 16'hFFFE;
    #1 release u_dut4.rd_count;
    for (int t = 0; t < 3; t++) begin
      txn(0, 1'b0, 10'h23F, '0, rd, lat_seen, busy_seen);
      lit("sat_read_data", rd, val);
    end
    lit("sat_rd_count", 128'(rdc[0]), 128'hFFFF);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Watchdog so a stuck run still terminates.
  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
